mmio_dma_master: RTL and testbench

- Memory-mapped bus initiator that copies a block of 32-bit words from a source address to a destination address.
- Drives the same address / write-data / write-enable / read-data bus that the CPU uses to reach the data memory, factorial unit and GPIO through the address decoder and read mux.
- Requests the bus and acts only while granted; the CPU-side arbiter owns the grant.
- Configured by a start pulse carrying source, destination and word count.

---
 rtl/soc_pkg.sv | 13 +
 rtl/dma_addr_stepper.sv | 31 +++
 rtl/mmio_dma_master.sv | 141 ++++++++++++++
 tb/tb_mmio_dma_master.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Shared SoC definitions: DMA state encoding, bus word size and the memory-map
// region bases used to select targets on the shared CPU/DMA bus.
package soc_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE} dma_state_t;

  localparam int WORD_BYTES = 4;

  localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
  localparam logic [31:0] FACT_BASE = 32'h0000_0800;
  localparam logic [31:0] GPIO_BASE = 32'h0000_0900;

endpackage

// File: rtl/dma_addr_stepper.sv
// Loadable 32-bit address register that advances by ADDR_STEP when enabled.
// Latency: one cycle from load/inc to addr; addr_next is combinational.
// Backpressure: none; the owner gates inc with its bus grant.
module dma_addr_stepper
  import soc_pkg::*;
#(
  parameter logic [31:0] ADDR_STEP = 32'(WORD_BYTES)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        inc,
  input  logic [31:0] load_val,
  output logic [31:0] addr,
  output logic [31:0] addr_next
);

  // Wraps modulo 2^32 with no indication.
  assign addr_next = addr + ADDR_STEP;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (inc) begin
      addr <= addr_next;
    end
  end

endmodule

// File: rtl/mmio_dma_master.sv
// Block-copy bus initiator (optional fill mode under DMA_FILL_EN): copies len words src->dst.
// Latency: one READ + one WRITE bus cycle per word; done pulses the cycle after the last write.
// Backpressure: holds state, address and data while bus_gnt is low; start ignored while busy.
module mmio_dma_master
  import soc_pkg::*;
#(
  parameter int unsigned LEN_W     = 8,
  parameter logic [31:0] ADDR_STEP = 32'(WORD_BYTES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
`ifdef DMA_FILL_EN
  input  logic             fill,
  input  logic [31:0]      fill_val,
`endif
  input  logic             bus_gnt,
  input  logic [31:0]      bus_rd,
  output logic             bus_req,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wd,
  output logic             bus_we,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_left
);

  dma_state_t  state;
  logic        fill_mode;
  logic        accept;
  logic        step;
  logic        fill_sel;
  logic [31:0] fill_word;
  logic [31:0] cur_src;
  logic [31:0] cur_dst;
  logic [31:0] src_next;
  logic [31:0] dst_next;

`ifdef DMA_FILL_EN
  assign fill_sel  = fill;
  assign fill_word = fill_val;
`else
  assign fill_sel  = 1'b0;
  assign fill_word = '0;
`endif

  assign accept = (state == IDLE) && start && (len != '0);
  assign step   = (state == WRITE) && bus_gnt;
  assign bus_we = step;

  dma_addr_stepper #(.ADDR_STEP(ADDR_STEP)) u_src_step (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .inc       (step),
    .load_val  (src_addr),
    .addr      (cur_src),
    .addr_next (src_next)
  );

  dma_addr_stepper #(.ADDR_STEP(ADDR_STEP)) u_dst_step (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .inc       (step),
    .load_val  (dst_addr),
    .addr      (cur_dst),
    .addr_next (dst_next)
  );

  // bus_addr is registered one state ahead, so it is loaded with the address
  // the next state will drive rather than the current stepper value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fill_mode  <= 1'b0;
      busy       <= 1'b0;
      bus_req    <= 1'b0;
      done       <= 1'b0;
      bus_addr   <= '0;
      bus_wd     <= '0;
      words_left <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              busy       <= 1'b1;
              bus_req    <= 1'b1;
              words_left <= len;
              fill_mode  <= fill_sel;
              if (fill_sel) begin
                state    <= WRITE;
                bus_addr <= dst_addr;
                bus_wd   <= fill_word;
              end else begin
                state    <= READ;
                bus_addr <= src_addr;
              end
            end
          end
        end
        READ: begin
          if (bus_gnt) begin
            bus_wd   <= bus_rd;
            bus_addr <= cur_dst;
            state    <= WRITE;
          end else begin
            bus_addr <= cur_src;
          end
        end
        WRITE: begin
          if (bus_gnt) begin
            words_left <= words_left - LEN_W'(1);
            if (words_left == LEN_W'(1)) begin
              state   <= IDLE;
              busy    <= 1'b0;
              bus_req <= 1'b0;
              done    <= 1'b1;
            end else if (fill_mode) begin
              bus_addr <= dst_next;
            end else begin
              state    <= READ;
              bus_addr <= src_next;
            end
          end else begin
            bus_addr <= cur_dst;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_dma_master.sv
// Bench for mmio_dma_master: transaction-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized grant/start traffic.
module tb_mmio_dma_master;
  import soc_pkg::*;

  localparam int LEN_W = 8;

  logic             clock    = 1'b0;
  logic             reset    = 1'b0;
  logic             start    = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len      = '0;
  logic             bus_gnt  = 1'b0;
  logic [31:0]      bus_rd;
  logic             bus_req;
  logic [31:0]      bus_addr;
  logic [31:0]      bus_wd;
  logic             bus_we;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] words_left;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
  } bus_op_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    int          off;
  } log_t;

  bus_op_t     exp_q[$];
  log_t        bus_log[$];
  int          done_log[$];
  logic        m_busy    = 1'b0;
  logic        m_done    = 1'b0;
  int          m_left    = 0;
  logic [31:0] m_wd      = '0;
  int          start_cyc = 0;

  logic [31:0] basic_addr [6] = '{32'h10, 32'h40, 32'h14, 32'h44, 32'h18, 32'h48};
  logic [31:0] wrap_addr  [4] = '{32'hFFFF_FFFC, 32'h500, 32'h0, 32'h504};

  mmio_dma_master #(.LEN_W(LEN_W), .ADDR_STEP(32'd4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .bus_gnt    (bus_gnt),
    .bus_rd     (bus_rd),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_wd     (bus_wd),
    .bus_we     (bus_we),
    .busy       (busy),
    .done       (done),
    .words_left (words_left)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  assign bus_rd = mem[bus_addr[11:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Expected bus operations of a whole copy, evaluated on a snapshot of memory
  // so overlapping source/destination ranges see earlier writes.
  task automatic build_ops(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] a, b, v;
    shadow = mem;
    for (int i = 0; i < n; i++) begin
      a = s + 32'(4 * i);
      b = d + 32'(4 * i);
      v = shadow[a[11:2]];
      exp_q.push_back('{a, 1'b0, 32'h0});
      exp_q.push_back('{b, 1'b1, v});
      shadow[b[11:2]] = v;
    end
  endtask

  always @(negedge clock) begin
    bus_op_t hd;
    logic    n_done;
    if (reset) begin
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_bus_req", 32'(bus_req), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_bus_we", 32'(bus_we), 32'h0);
      chk("rst_words_left", 32'(words_left), 32'h0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wd", bus_wd, 32'h0);
      exp_q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      m_wd   = '0;
    end else begin
      n_done = 1'b0;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("bus_req", 32'(bus_req), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("words_left", 32'(words_left), 32'(m_left));
      if (m_busy && exp_q.size() > 0) begin
        hd = exp_q[0];
        chk("bus_addr", bus_addr, hd.addr);
        chk("bus_we", 32'(bus_we), 32'(hd.we & bus_gnt));
        chk("bus_wd", bus_wd, hd.we ? hd.wd : m_wd);
        if (bus_we) mem[bus_addr[11:2]] = bus_wd;
        if (bus_gnt) begin
          bus_log.push_back('{bus_addr, bus_we, bus_wd, cyc - start_cyc});
          void'(exp_q.pop_front());
          if (hd.we) begin
            m_left--;
            m_wd = hd.wd;
            if (exp_q.size() == 0) begin
              m_busy = 1'b0;
              n_done = 1'b1;
            end
          end
        end
      end else begin
        chk("bus_we_idle", 32'(bus_we), 32'h0);
        chk("bus_wd_idle", bus_wd, m_wd);
        if (start) begin
          start_cyc = cyc;
          if (len == '0) begin
            n_done = 1'b1;
          end else begin
            build_ops(src_addr, dst_addr, int'(len));
            m_busy = 1'b1;
            m_left = int'(len);
          end
        end
      end
      if (done) done_log.push_back(cyc - start_cyc);
      m_done = n_done;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    len      = LEN_W'(n);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout got=done_low want=done_within_%0d", nm, budget);
    end
    tick(1);
  endtask

  task automatic clear_logs();
    bus_log.delete();
    done_log.delete();
  endtask

  function automatic logic [31:0] first_done();
    return (done_log.size() == 1) ? 32'(done_log[0]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    logic [31:0] stall_v;
    logic [31:0] ga;
    int          k;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    #1 reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("reset_idle_busy", 32'(busy), 32'h0);

    // Basic copy 0x10 -> 0x40, 3 words.
    bus_gnt = 1'b1;
    mem[4] = 32'hA0;
    mem[5] = 32'hA1;
    mem[6] = 32'hA2;
    clear_logs();
    pulse_start(32'h10, 32'h40, 3);
    wait_done("basic", 20);
    chk("basic_nops", 32'(bus_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < bus_log.size(); i++) begin
      chk("basic_addr", bus_log[i].addr, basic_addr[i]);
      chk("basic_we", 32'(bus_log[i].we), 32'(i % 2));
      if (i % 2 == 1) chk("basic_wd", bus_log[i].wd, 32'hA0 + 32'(i / 2));
    end
    chk("basic_done_cycle", first_done(), 32'd7);

    // Zero length: immediate done, no bus activity.
    clear_logs();
    pulse_start(32'h20, 32'h60, 0);
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_req", 32'(bus_req), 32'h0);
    chk("zero_busy", 32'(busy), 32'h0);
    tick(1);
    chk("zero_done_clear", 32'(done), 32'h0);
    chk("zero_nops", 32'(bus_log.size()), 32'h0);
    chk("zero_done_cycle", first_done(), 32'd1);

    // Grant stall of 3 cycles during the first WRITE.
    clear_logs();
    stall_v = mem[64];
    pulse_start(32'h100, 32'h200, 2);
    tick(1);
    bus_gnt = 1'b0;
    tick(1);
    chk("stall_we", 32'(bus_we), 32'h0);
    chk("stall_words_left", 32'(words_left), 32'd2);
    chk("stall_addr", bus_addr, 32'h200);
    chk("stall_wd", bus_wd, stall_v);
    tick(2);
    bus_gnt = 1'b1;
    wait_done("stall", 20);
    chk("stall_done_cycle", first_done(), 32'd8);

    // Peripheral target: one word into the GPIO region.
    clear_logs();
    mem[0] = 32'h0000_001F;
    pulse_start(DMEM_BASE, GPIO_BASE, 1);
    wait_done("gpio", 10);
    chk("gpio_nops", 32'(bus_log.size()), 32'd2);
    if (bus_log.size() == 2) begin
      chk("gpio_we", 32'(bus_log[1].we), 32'h1);
      chk("gpio_addr", bus_log[1].addr, 32'h900);
      chk("gpio_wd", bus_log[1].wd, 32'h1F);
    end
    ga = GPIO_BASE;
    chk("gpio_mem", mem[ga[11:2]], 32'h1F);

    // Reset during the second READ of a 4-word copy, then a normal 1-word copy.
    clear_logs();
    pulse_start(32'h300, 32'h380, 4);
    tick(2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_req", 32'(bus_req), 32'h0);
    chk("async_rst_left", 32'(words_left), 32'h0);
    chk("async_rst_addr", bus_addr, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(3);
    chk("rst_no_done", 32'(done_log.size()), 32'h0);
    pulse_start(32'h300, 32'h380, 1);
    wait_done("after_rst", 10);
    chk("after_rst_done_cycle", first_done(), 32'd3);

    // Source wrap across 2^32 and a start pulse while busy.
    clear_logs();
    pulse_start(32'hFFFF_FFFC, 32'h500, 2);
    tick(2);
    start    = 1'b1;
    src_addr = 32'h600;
    dst_addr = 32'h700;
    len      = LEN_W'(5);
    tick(1);
    start = 1'b0;
    wait_done("wrap", 20);
    tick(3);
    chk("wrap_nops", 32'(bus_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < bus_log.size(); i++) chk("wrap_addr", bus_log[i].addr, wrap_addr[i]);
    chk("wrap_done_cycle", first_done(), 32'd5);
    chk("wrap_idle_after", 32'(busy), 32'h0);

    // Randomized grant and start traffic, with one asynchronous reset.
    for (int c = 0; c < 4000; c++) begin
      bus_gnt  = ($urandom_range(0, 9) < 7);
      start    = ($urandom_range(0, 7) == 0);
      src_addr = $urandom_range(0, 1) ? 32'($urandom_range(0, 127)) * 32'd4 : ($urandom & ~32'h3);
      dst_addr = $urandom_range(0, 1) ? 32'($urandom_range(0, 127)) * 32'd4 : ($urandom & ~32'h3);
      len      = LEN_W'($urandom_range(0, 6));
      if (c == 2000) begin
        #2 reset = 1'b1;
        #4 reset = 1'b0;
      end
      tick(1);
    end
    start   = 1'b0;
    bus_gnt = 1'b1;
    k = 0;
    while ((busy || done) && k < 50) begin
      tick(1);
      k++;
    end
    chk("rand_drain_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
